// File: rtl/i2c_bme280_responder.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bme280_responder
// Brief    : I2C target emulating the BME280 register map (0x80-0xFF) with host preload
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bme280_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h76,
    parameter logic [7:0] CHIP_ID  = 8'h60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_pad_in,
    input  logic       sda_pad_in,
    output logic       sda_pad_out,
    output logic       sda_pad_en,
    input  logic       host_we,
    input  logic [6:0] host_addr,
    input  logic [7:0] host_data,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam logic [3:0] c_st_idle      = 4'd0;
    localparam logic [3:0] c_st_addr      = 4'd1;
    localparam logic [3:0] c_st_addr_ack  = 4'd2;
    localparam logic [3:0] c_st_reg       = 4'd3;
    localparam logic [3:0] c_st_reg_ack   = 4'd4;
    localparam logic [3:0] c_st_wdata     = 4'd5;
    localparam logic [3:0] c_st_wdata_ack = 4'd6;
    localparam logic [3:0] c_st_rdata     = 4'd7;
    localparam logic [3:0] c_st_rdata_ack = 4'd8;

    localparam logic [7:0] c_chip_id_reg  = 8'hD0;
    localparam logic [6:0] c_chip_id_idx  = 7'h50;

    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0] r_state, w_state_nxt;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_tx;
    logic [7:0] r_ptr;
    logic       r_rw;
    logic       r_mack;
    logic       r_sda_en;
    logic       r_busy;
    logic       r_wr_strobe;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic [7:0] r_mem [0:127];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic       w_byte_done, w_addr_match, w_bit_state;
    logic [7:0] w_rd_addr, w_rd_byte;
    logic       w_sda_en_nxt, w_ptr_load, w_ptr_inc, w_tx_load, w_tx_shift;
    logic       w_commit, w_commit_en;

    // Two synchronizer flops plus one history flop per line for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_pad_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_pad_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise   = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall   = ~r_scl_s2 & r_scl_d;
    assign w_start      = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop       = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte_done  = w_scl_fall && (r_bit_cnt == 4'd8);
    assign w_addr_match = (r_shift[7:1] == DEV_ADDR);
    assign w_bit_state  = (r_state == c_st_addr) || (r_state == c_st_reg) ||
                          (r_state == c_st_wdata) || (r_state == c_st_rdata);

    // During the read ACK bit the next byte (pointer + 1) is fetched in advance.
    assign w_rd_addr = (r_state == c_st_rdata_ack) ? (r_ptr + 8'd1) : r_ptr;

    always_comb begin
        w_rd_byte = 8'h00;
        if (w_rd_addr == c_chip_id_reg) begin
            w_rd_byte = CHIP_ID;
        end else if (w_rd_addr[7]) begin
            w_rd_byte = r_mem[w_rd_addr[6:0]];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = c_st_addr;
        end else if (w_stop) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_addr:      if (w_byte_done) w_state_nxt = w_addr_match ? c_st_addr_ack : c_st_idle;
                c_st_addr_ack:  if (w_scl_fall)  w_state_nxt = r_rw ? c_st_rdata : c_st_reg;
                c_st_reg:       if (w_byte_done) w_state_nxt = c_st_reg_ack;
                c_st_reg_ack:   if (w_scl_fall)  w_state_nxt = c_st_wdata;
                c_st_wdata:     if (w_byte_done) w_state_nxt = c_st_wdata_ack;
                c_st_wdata_ack: if (w_scl_fall)  w_state_nxt = c_st_wdata;
                c_st_rdata:     if (w_byte_done) w_state_nxt = c_st_rdata_ack;
                c_st_rdata_ack: if (w_scl_fall)  w_state_nxt = r_mack ? c_st_rdata : c_st_idle;
                default:        w_state_nxt = c_st_idle;
            endcase
        end
    end

    // Output / datapath control decode
    always_comb begin
        w_sda_en_nxt = r_sda_en;
        w_ptr_load   = 1'b0;
        w_ptr_inc    = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_shift   = 1'b0;
        w_commit     = 1'b0;
        if (w_start || w_stop) begin
            w_sda_en_nxt = 1'b1;
        end else begin
            case (r_state)
                c_st_addr: begin
                    if (w_byte_done) w_sda_en_nxt = ~w_addr_match;
                end
                c_st_addr_ack: begin
                    if (w_scl_fall) begin
                        w_tx_load    = r_rw;
                        w_sda_en_nxt = r_rw ? w_rd_byte[7] : 1'b1;
                    end
                end
                c_st_reg: begin
                    if (w_byte_done) begin
                        w_ptr_load   = 1'b1;
                        w_sda_en_nxt = 1'b0;
                    end
                end
                c_st_wdata: begin
                    if (w_byte_done) w_sda_en_nxt = 1'b0;
                end
                c_st_reg_ack: begin
                    if (w_scl_fall) w_sda_en_nxt = 1'b1;
                end
                c_st_wdata_ack: begin
                    if (w_scl_rise) begin
                        w_commit  = 1'b1;
                        w_ptr_inc = 1'b1;
                    end
                    if (w_scl_fall) w_sda_en_nxt = 1'b1;
                end
                c_st_rdata: begin
                    if (w_byte_done) begin
                        w_sda_en_nxt = 1'b1;
                    end else if (w_scl_fall) begin
                        w_tx_shift   = 1'b1;
                        w_sda_en_nxt = r_tx[6];
                    end
                end
                c_st_rdata_ack: begin
                    if (w_scl_fall) begin
                        w_ptr_inc    = r_mack;
                        w_tx_load    = r_mack;
                        w_sda_en_nxt = r_mack ? w_rd_byte[7] : 1'b1;
                    end
                end
                default: w_sda_en_nxt = 1'b1;
            endcase
        end
    end

    assign w_commit_en = w_commit && r_ptr[7] && (r_ptr != c_chip_id_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_tx        <= 8'h00;
            r_ptr       <= 8'h00;
            r_rw        <= 1'b0;
            r_mack      <= 1'b0;
            r_sda_en    <= 1'b1;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 8'h00;
            r_wr_data   <= 8'h00;
        end else begin
            r_sda_en    <= w_sda_en_nxt;
            r_wr_strobe <= w_commit_en;
            if (w_start || (w_state_nxt != r_state)) begin
                r_bit_cnt <= 4'd0;
            end else if (w_scl_rise && w_bit_state) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_scl_rise && ((r_state == c_st_addr) || (r_state == c_st_reg) ||
                               (r_state == c_st_wdata))) begin
                r_shift <= {r_shift[6:0], r_sda_s2};
            end
            if ((r_state == c_st_addr) && (w_state_nxt == c_st_addr_ack)) begin
                r_rw <= r_shift[0];
            end
            if (w_stop) begin
                r_busy <= 1'b0;
            end else if ((r_state == c_st_addr) && (w_state_nxt == c_st_addr_ack)) begin
                r_busy <= 1'b1;
            end
            if (w_ptr_load) begin
                r_ptr <= r_shift;
            end else if (w_ptr_inc) begin
                r_ptr <= r_ptr + 8'd1;
            end
            if (w_tx_load) begin
                r_tx <= w_rd_byte;
            end else if (w_tx_shift) begin
                r_tx <= {r_tx[6:0], 1'b1};
            end
            if ((r_state == c_st_rdata_ack) && w_scl_rise) begin
                r_mack <= ~r_sda_s2;
            end
            if (w_commit_en) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= r_shift;
            end
        end
    end

    // Host preload first, I2C commit second so the bus write wins on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (host_we && (host_addr != c_chip_id_idx)) begin
                r_mem[host_addr] <= host_data;
            end
            if (w_commit_en) begin
                r_mem[r_ptr[6:0]] <= r_shift;
            end
        end
    end

    assign sda_pad_out = 1'b0;
    assign sda_pad_en  = r_sda_en;
    assign busy        = r_busy;
    assign wr_strobe   = r_wr_strobe;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;

endmodule
`default_nettype wire
